// File: rtl/reg_file_sb.sv
// Parametrised CPU register file: clear sequencer, write-to-read bypass and busy scoreboard.
// Optional trace output is compiled in when REG_FILE_TRACE_EN is defined.
module reg_file_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NRD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      busy,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                alloc,
    input  logic [AW-1:0]       alloc_addr
);

    localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   clr_ptr;
    logic [AW-1:0]   clr_ptr_nxt;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] sb;
    logic            wr_en;
    logic            al_en;
    logic [AW-1:0]   ra;
    logic            byp;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // Next-state: walk every register once, then hold in RUN
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            CLEAR: begin
                if (clr_ptr == LAST_REG) begin
                    state_nxt = RUN;
                end else begin
                    clr_ptr_nxt = clr_ptr + AW'(1);
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        ready = 1'b0;
        wr_en = 1'b0;
        al_en = 1'b0;
        if (state == RUN) begin
            ready = 1'b1;
            wr_en = we && (waddr != '0);
            al_en = alloc && (alloc_addr != '0);
        end
    end

    // Storage: no reset, the sequencer zeroes it after every reset
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[clr_ptr] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Scoreboard: alloc is applied after the write-clear so a new producer wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= '0;
        end else begin
            if (wr_en) sb[waddr] <= 1'b0;
            if (al_en) sb[alloc_addr] <= 1'b1;
        end
    end

    // Read ports with zero-cycle forwarding from the write port
    always_comb begin
        rdata = '0;
        busy  = '0;
        ra    = '0;
        byp   = 1'b0;
        if (state == RUN) begin
            for (int k = 0; k < int'(NRD); k++) begin
                ra  = raddr[k*AW +: AW];
                byp = we && (waddr == ra);
                if (ra != '0) begin
                    rdata[k*XLEN +: XLEN] = byp ? wdata : regs[ra];
                    busy[k]               = sb[ra] && !byp;
                end
            end
        end
    end

`ifdef REG_FILE_TRACE_EN
    string trace_line;
    always @(posedge clk) begin
        if (!rst && state == RUN) begin
            trace_line = "CPUv2:";
            for (int i = 0; i < 16; i++) begin
                if (i < int'(NREGS)) begin
                    trace_line = {trace_line, $sformatf(" %h", (i == 0) ? XLEN'(0) : regs[AW'(i)])};
                end
            end
            $strobe("%s", trace_line);
            if (wr_en) $strobe("CPUv2: wr x%0d <= %h", waddr, wdata);
            if (al_en) $strobe("CPUv2: alloc x%0d", alloc_addr);
        end
    end
`endif

endmodule
